// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI receive peripheral: register map, status
// byte classes, parsed-message layout and the serial PHY state encoding.
package midi_pkg;

  localparam logic [1:0] ADR_MSG  = 2'd0;
  localparam logic [1:0] ADR_STAT = 2'd1;
  localparam logic [1:0] ADR_CTRL = 2'd2;

  localparam int STAT_NE      = 0;
  localparam int STAT_OVR     = 1;
  localparam int STAT_FERR    = 2;
  localparam int STAT_CNT_LSB = 4;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_RX_EN  = 1;

  localparam logic [7:0] CH_LO = 8'h80;
  localparam logic [7:0] CH_HI = 8'hEF;
  localparam logic [7:0] SC_LO = 8'hF0;
  localparam logic [7:0] SC_HI = 8'hF7;
  localparam logic [7:0] RT_LO = 8'hF8;

  localparam int MSG_VALID_BIT = 31;
  localparam int MSG_LEN_LSB   = 24;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} phy_state_e;

  typedef struct packed {
    logic [1:0] len;
    logic [7:0] status;
    logic [7:0] d1;
    logic [7:0] d2;
  } msg_t;

  // Data bytes that follow a status byte; only channel messages carry any.
  function automatic logic [1:0] data_len(input logic [7:0] st);
    logic [1:0] n;
    n = 2'd0;
    if (st >= CH_LO && st <= CH_HI) begin
      n = (st[7:4] == 4'hC || st[7:4] == 4'hD) ? 2'd1 : 2'd2;
    end
    return n;
  endfunction

  function automatic logic [31:0] msg_word(input msg_t m);
    logic [31:0] w;
    w = '0;
    w[MSG_VALID_BIT] = 1'b1;
    w[MSG_LEN_LSB +: 2] = m.len;
    w[23:0] = {m.status, m.d1, m.d2};
    return w;
  endfunction

endpackage

// File: rtl/wb_midi_rx_if.sv
// Wishbone classic slave bundle for the MIDI receive peripheral.
interface wb_midi_rx_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/midi_rx_phy.sv
// MIDI serial deserialiser: 2-FF synchroniser, start/data/stop bit FSM
// with mid-bit sampling, byte strobe and framing-error strobe.
module midi_rx_phy
  import midi_pkg::*;
#(
  parameter int BIT_CYC = 3200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_i,
  input  logic       rx_en_i,
  output logic [7:0] byte_o,
  output logic       byte_stb_o,
  output logic       ferr_stb_o
);

  localparam int CW = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
  localparam logic [CW-1:0] HALF_LD = CW'(BIT_CYC / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(BIT_CYC - 1);

  logic [1:0]    sync_q;
  logic          prev_q, prev_d;
  phy_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          stb_q, stb_d;
  logic          ferr_q, ferr_d;
  logic          rxd_s, tick;

  assign rxd_s = sync_q[1];
  assign tick  = (cnt_q == '0);

  always_comb begin
    prev_d  = rxd_s;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    stb_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_en_i && prev_q && !rxd_s) begin
          state_d = S_START;
          cnt_d   = HALF_LD;
        end
      end
      S_START: begin
        if (!tick) cnt_d = cnt_q - CW'(1);
        else if (rxd_s) state_d = S_IDLE;
        else begin
          state_d = S_DATA;
          cnt_d   = FULL_LD;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (!tick) cnt_d = cnt_q - CW'(1);
        else begin
          sh_d  = {rxd_s, sh_q[7:1]};
          cnt_d = FULL_LD;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (!tick) cnt_d = cnt_q - CW'(1);
        else begin
          state_d = S_IDLE;
          stb_d   = rxd_s;
          ferr_d  = !rxd_s;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Synchroniser and edge history clear to low so a line still held low
  // after reset cannot masquerade as a falling edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= 2'b00;
      prev_q  <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      stb_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd_i};
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      stb_q   <= stb_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_o     = sh_q;
  assign byte_stb_o = stb_q;
  assign ferr_stb_o = ferr_q;

endmodule

// File: rtl/wb_midi_rx.sv
// MIDI input peripheral: serial PHY, running-status message parser,
// small message FIFO and Wishbone register file with level interrupt.
module wb_midi_rx
  import midi_pkg::*;
#(
  parameter int clk_freq = 100000000,
  parameter int baud     = 31250,
  parameter int fifo_aw  = 2
) (
  input  logic         clk,
  input  logic         rst,
  wb_midi_rx_if.slave  wb,
  input  logic         midi_rxd,
  output logic         irq
);

  localparam int BIT_CYC = clk_freq / baud;
  localparam int DEPTH   = 1 << fifo_aw;
  localparam int CNTW    = fifo_aw + 1;

  logic [7:0] rx_byte;
  logic       byte_stb, ferr_stb;

  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic              irq_q, irq_d;
  logic              irq_en_q, irq_en_d;
  logic              rx_en_q, rx_en_d;
  logic              ovr_q, ovr_d;
  logic              ferr_q, ferr_d;
  logic [7:0]        run_q, run_d;
  logic [1:0]        need_q, need_d;
  logic              idx_q, idx_d;
  logic [7:0]        d1_q, d1_d;
  logic [fifo_aw-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  msg_t              mem_q [DEPTH];

  msg_t        push_msg;
  logic        push, pop, wr, nonempty, full, access;
  logic [31:0] stat_w, ctrl_w;
  logic        unused_ok;

  midi_rx_phy #(.BIT_CYC(BIT_CYC)) u_phy (
    .clk        (clk),
    .rst        (rst),
    .rxd_i      (midi_rxd),
    .rx_en_i    (rx_en_q),
    .byte_o     (rx_byte),
    .byte_stb_o (byte_stb),
    .ferr_stb_o (ferr_stb)
  );

  assign nonempty = (cnt_q != '0);
  assign full     = (cnt_q == CNTW'(DEPTH));
  assign access   = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign unused_ok = ^{wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_dat_i[31:3]};

  always_comb begin
    stat_w = '0;
    stat_w[STAT_NE]   = nonempty;
    stat_w[STAT_OVR]  = ovr_q;
    stat_w[STAT_FERR] = ferr_q;
    stat_w[STAT_CNT_LSB +: CNTW] = cnt_q;
    ctrl_w = '0;
    ctrl_w[CTRL_IRQ_EN] = irq_en_q;
    ctrl_w[CTRL_RX_EN]  = rx_en_q;
  end

  // Parser: realtime bytes bypass the running-status context entirely.
  always_comb begin
    push     = 1'b0;
    push_msg = '0;
    run_d    = run_q;
    need_d   = need_q;
    idx_d    = idx_q;
    d1_d     = d1_q;
    if (byte_stb) begin
      if (rx_byte >= RT_LO) begin
        push            = 1'b1;
        push_msg.len    = 2'd1;
        push_msg.status = rx_byte;
      end else if (rx_byte >= SC_LO) begin
        run_d = 8'd0;
        idx_d = 1'b0;
      end else if (rx_byte[7]) begin
        run_d  = rx_byte;
        need_d = data_len(rx_byte);
        idx_d  = 1'b0;
      end else if (run_q != 8'd0) begin
        if (!idx_q && need_q == 2'd2) begin
          d1_d  = rx_byte;
          idx_d = 1'b1;
        end else begin
          push            = 1'b1;
          push_msg.len    = need_q + 2'd1;
          push_msg.status = run_q;
          push_msg.d1     = (need_q == 2'd1) ? rx_byte : d1_q;
          push_msg.d2     = (need_q == 2'd1) ? 8'd0 : rx_byte;
          idx_d           = 1'b0;
        end
      end
    end
  end

  always_comb begin
    ack_d    = access;
    dat_d    = '0;
    pop      = 1'b0;
    irq_en_d = irq_en_q;
    rx_en_d  = rx_en_q;
    ovr_d    = ovr_q;
    ferr_d   = ferr_q;
    if (access && !wb.wb_we_i) begin
      case (wb.wb_adr_i[3:2])
        ADR_MSG: begin
          if (nonempty) begin
            dat_d = msg_word(mem_q[rp_q]);
            pop   = 1'b1;
          end
        end
        ADR_STAT: dat_d = stat_w;
        ADR_CTRL: dat_d = ctrl_w;
        default:  dat_d = '0;
      endcase
    end
    if (access && wb.wb_we_i) begin
      case (wb.wb_adr_i[3:2])
        ADR_STAT: begin
          if (wb.wb_dat_i[STAT_OVR])  ovr_d  = 1'b0;
          if (wb.wb_dat_i[STAT_FERR]) ferr_d = 1'b0;
        end
        ADR_CTRL: begin
          irq_en_d = wb.wb_dat_i[CTRL_IRQ_EN];
          rx_en_d  = wb.wb_dat_i[CTRL_RX_EN];
        end
        default: ;
      endcase
    end
    if (ferr_stb) ferr_d = 1'b1;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    wr = push & (~full | pop);
    if (push && !wr) ovr_d = 1'b1;
    wp_d = wr  ? wp_q + fifo_aw'(1) : wp_q;
    rp_d = pop ? rp_q + fifo_aw'(1) : rp_q;
    case ({wr, pop})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
    irq_d = irq_en_q & nonempty;
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= push_msg;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
      irq_en_q <= 1'b0;
      rx_en_q  <= 1'b1;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      run_q    <= 8'd0;
      need_q   <= 2'd0;
      idx_q    <= 1'b0;
      d1_q     <= 8'd0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
      irq_en_q <= irq_en_d;
      rx_en_q  <= rx_en_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
      run_q    <= run_d;
      need_q   <= need_d;
      idx_q    <= idx_d;
      d1_q     <= d1_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_wb_midi_rx.sv
// Bench for wb_midi_rx: directed MIDI scenarios plus random byte streams
// checked against a message-level reference model.
module tb_wb_midi_rx;

  localparam int CLK_FREQ = 500000;
  localparam int BAUD     = 31250;
  localparam int BIT_CYC  = CLK_FREQ / BAUD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic midi_rxd = 1'b1;
  logic irq;
  int n_cmp = 0;
  int n_err = 0;

  wb_midi_rx_if wb();

  wb_midi_rx #(.clk_freq(CLK_FREQ), .baud(BAUD), .fifo_aw(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb       (wb),
    .midi_rxd (midi_rxd),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [7:0]  m_run;
  int          m_need, m_have;
  logic [7:0]  m_d [2];
  logic [31:0] m_q [$];
  bit          m_ovr;

  function automatic void model_reset();
    m_run = 8'd0; m_need = 0; m_have = 0; m_ovr = 1'b0;
    m_q.delete();
  endfunction

  function automatic void model_push(input int len, input logic [7:0] s, a, b);
    if (m_q.size() >= 4) m_ovr = 1'b1;
    else m_q.push_back(32'h8000_0000 | (len << 24) | (s << 16) | (a << 8) | b);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'hF8) model_push(1, b, 8'd0, 8'd0);
    else if (b >= 8'hF0) begin m_run = 8'd0; m_have = 0; end
    else if (b >= 8'h80) begin
      m_run = b; m_have = 0;
      m_need = (b[7:4] == 4'hC || b[7:4] == 4'hD) ? 1 : 2;
    end else if (m_run != 8'd0) begin
      m_d[m_have] = b;
      m_have++;
      if (m_have == m_need) begin
        model_push(m_need + 1, m_run, m_d[0], (m_need == 2) ? m_d[1] : 8'd0);
        m_have = 0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop = 1'b1);
    midi_rxd = 1'b0;
    cycles(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      midi_rxd = b[i];
      cycles(BIT_CYC);
    end
    midi_rxd = stop;
    cycles(BIT_CYC);
    midi_rxd = 1'b1;
  endtask

  task automatic settle();
    cycles(2 * BIT_CYC);
  endtask

  task automatic wb_xfer(input logic [3:0] adr, input bit we, input logic [31:0] wd,
                         output logic [31:0] rd);
    int t;
    wb.wb_adr_i = {28'd0, adr};
    wb.wb_we_i  = we;
    wb.wb_dat_i = wd;
    wb.wb_stb_i = 1'b1;
    wb.wb_cyc_i = 1'b1;
    t = 0;
    do begin tick(); t++; end while (!wb.wb_ack_o && t < 8);
    if (!wb.wb_ack_o) begin
      n_cmp++; n_err++;
      $display("FAIL wb_ack_timeout: adr=%h no ack within 8 cycles", adr);
      rd = 32'hDEAD_BEEF;
    end else rd = wb.wb_dat_o;
    wb.wb_stb_i = 1'b0;
    wb.wb_cyc_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    tick();
  endtask

  task automatic wb_rd(input logic [3:0] adr, output logic [31:0] d);
    wb_xfer(adr, 1'b0, 32'd0, d);
  endtask

  task automatic wb_wr(input logic [3:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(adr, 1'b1, d, dummy);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0;
    cycles(3);
    n_cmp++; if (wb.wb_ack_o !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b exp 0", wb.wb_ack_o); end
    n_cmp++; if (wb.wb_dat_o !== 32'd0) begin n_err++; $display("FAIL rst_dat: got %h exp 0", wb.wb_dat_o); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b exp 0", irq); end
    rst = 1'b1;
    cycles(4);
    wb_rd(4'h4, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_stat: got %h exp 0", d); end
    wb_rd(4'h8, d);
    n_cmp++; if (d !== 32'h2) begin n_err++; $display("FAIL rst_ctrl: got %h exp 2", d); end
    wb_rd(4'h0, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_msg: got %h exp 0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    wb_wr(4'h8, 32'h0);
    send_byte(8'hF8);
    settle();
    wb_rd(4'h4, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rx_disabled_stat: got %h exp 0", d); end
    wb_wr(4'hC, 32'hFFFF_FFFF);
    wb_wr(4'h0, 32'hFFFF_FFFF);
    wb_rd(4'h8, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL unmapped_wr_ctrl: got %h exp 0", d); end
    wb_wr(4'h8, 32'h2);
  endtask

  task automatic test_note_on();
    logic [31:0] d;
    wb_wr(4'h8, 32'h3);
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    settle();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL note_irq_high: got %b exp 1", irq); end
    wb_rd(4'h0, d);
    n_cmp++; if (d !== 32'h8390_3C64) begin n_err++; $display("FAIL note_msg: got %h exp 83903c64", d); end
    wb_rd(4'h0, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL note_empty: got %h exp 0", d); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL note_irq_low: got %b exp 0", irq); end
  endtask

  task automatic test_running_status();
    logic [31:0] d;
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64); send_byte(8'h3E); send_byte(8'h00);
    settle();
    wb_rd(4'h0, d);
    n_cmp++; if (d !== 32'h8390_3C64) begin n_err++; $display("FAIL rs_msg0: got %h exp 83903c64", d); end
    wb_rd(4'h0, d);
    n_cmp++; if (d !== 32'h8390_3E00) begin n_err++; $display("FAIL rs_msg1: got %h exp 83903e00", d); end
  endtask

  task automatic test_realtime();
    logic [31:0] d;
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF8); send_byte(8'h64);
    settle();
    wb_rd(4'h0, d);
    n_cmp++; if (d !== 32'h81F8_0000) begin n_err++; $display("FAIL rt_msg0: got %h exp 81f80000", d); end
    wb_rd(4'h0, d);
    n_cmp++; if (d !== 32'h8390_3C64) begin n_err++; $display("FAIL rt_msg1: got %h exp 83903c64", d); end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    send_byte(8'hC0);
    for (int i = 0; i < 5; i++) send_byte(8'(i));
    settle();
    wb_rd(4'h4, d);
    n_cmp++; if (d !== 32'h43) begin n_err++; $display("FAIL ovr_stat: got %h exp 43", d); end
    for (int i = 0; i < 4; i++) begin
      wb_rd(4'h0, d);
      n_cmp++;
      if (d !== (32'h82C0_0000 | (i << 8))) begin
        n_err++; $display("FAIL ovr_msg%0d: got %h exp %h", i, d, 32'h82C0_0000 | (i << 8));
      end
    end
    wb_wr(4'h4, 32'h2);
    wb_rd(4'h4, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL ovr_clear: got %h exp 0", d); end
  endtask

  task automatic test_framing();
    logic [31:0] d;
    send_byte(8'h55, 1'b0);
    settle();
    wb_rd(4'h4, d);
    n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL ferr_stat: got %h exp 4", d); end
    wb_wr(4'h4, 32'h4);
    wb_rd(4'h4, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL ferr_clear: got %h exp 0", d); end
    send_byte(8'hC0); send_byte(8'hF2); send_byte(8'h40);
    settle();
    wb_rd(4'h4, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL orphan_stat: got %h exp 0", d); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    logic [7:0] b;
    b = 8'h5A;
    wb_wr(4'h8, 32'h3);
    send_byte(8'hF8);
    settle();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL mid_irq_pre: got %b exp 1", irq); end
    send_byte(8'h90);
    midi_rxd = 1'b0;
    cycles(BIT_CYC);
    for (int i = 0; i < 3; i++) begin midi_rxd = b[i]; cycles(BIT_CYC); end
    midi_rxd = b[3];
    cycles(BIT_CYC / 2);
    rst = 1'b0;
    cycles(2);
    n_cmp++; if ({irq, wb.wb_ack_o} !== 2'b00 || wb.wb_dat_o !== 32'd0) begin
      n_err++; $display("FAIL mid_outputs: irq=%b ack=%b dat=%h exp all 0", irq, wb.wb_ack_o, wb.wb_dat_o);
    end
    rst = 1'b1;
    midi_rxd = 1'b1;
    cycles(3 * BIT_CYC);
    wb_rd(4'h4, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL mid_stat: got %h exp 0", d); end
    wb_rd(4'h8, d);
    n_cmp++; if (d !== 32'h2) begin n_err++; $display("FAIL mid_ctrl: got %h exp 2", d); end
    send_byte(8'h40); send_byte(8'hFE);
    settle();
    wb_rd(4'h0, d);
    n_cmp++; if (d !== 32'h81FE_0000) begin n_err++; $display("FAIL mid_msg: got %h exp 81fe0000", d); end
    wb_rd(4'h0, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL mid_empty: got %h exp 0", d); end
  endtask

  task automatic test_random();
    logic [31:0] d, exp_w;
    logic [7:0] b;
    int k;
    wb_wr(4'h4, 32'h6);
    model_reset();
    for (int c = 0; c < 8; c++) begin
      for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
        k = $urandom_range(0, 99);
        if (k < 40)      b = 8'($urandom_range(8'h00, 8'h7F));
        else if (k < 75) b = 8'($urandom_range(8'h80, 8'hEF));
        else if (k < 85) b = 8'($urandom_range(8'hF0, 8'hF7));
        else             b = 8'($urandom_range(8'hF8, 8'hFF));
        model_byte(b);
        send_byte(b);
        cycles($urandom_range(0, BIT_CYC));
      end
      settle();
      exp_w = (m_q.size() << 4) | (32'(m_ovr) << 1) | 32'(m_q.size() != 0);
      wb_rd(4'h4, d);
      n_cmp++; if (d !== exp_w) begin n_err++; $display("FAIL rnd_stat%0d: got %h exp %h", c, d, exp_w); end
      while (m_q.size() != 0) begin
        exp_w = m_q.pop_front();
        wb_rd(4'h0, d);
        n_cmp++; if (d !== exp_w) begin n_err++; $display("FAIL rnd_msg%0d: got %h exp %h", c, d, exp_w); end
      end
      wb_rd(4'h0, d);
      n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rnd_empty%0d: got %h exp 0", c, d); end
      wb_wr(4'h4, 32'h2);
      m_ovr = 1'b0;
    end
  endtask

  initial begin
    wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = 4'hF;
    wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_we_i = 1'b0;
    test_reset();
    test_regs();
    test_note_on();
    test_running_status();
    test_realtime();
    test_overrun();
    test_framing();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/wb_midi_rx.md
# wb_midi_rx

MIDI input port for the LM32 SoC: a Wishbone slave that deserialises a 31250-baud MIDI serial stream and parses it into complete channel/realtime messages. It handles running status and realtime interleaving, buffers parsed messages in a 4-entry FIFO, and raises a level interrupt while messages are pending. It complements the existing MIDI output peripheral and attaches to a free conbus slave port.

## Interface
- clk_freq, 100000000, system clock in Hz
- baud, 31250, MIDI bit rate; BIT_CYC = clk_freq/baud (3200 at defaults)
- fifo_aw, 2, FIFO address width (depth 2^fifo_aw = 4)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-low
- wb_adr_i  in  32  byte address; only [3:2] decoded
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, registered
- wb_sel_i  in  4  byte selects, ignored (full-word access only)
- wb_stb_i, wb_cyc_i, wb_we_i  in  1  Wishbone classic strobe, cycle, write
- wb_ack_o  out  1  one-cycle acknowledge
- midi_rxd  in  1  asynchronous serial input, idle high
- irq  out  1  active-high level interrupt

## Operation
- Registers, word offsets:
  - 0x0 MSG (RO, read pops): [31] valid, [25:24] length 1..3, [23:16] status, [15:8] data1, [7:0] data2; unused bytes 0.
  - 0x4 STAT: [0] nonempty, [1] overrun (sticky), [2] framing error (sticky), [6:4] count 0..4. Writing 1 to bit 1 or bit 2 clears that bit.
  - 0x8 CTRL (RW): [0] irq_en, [1] rx_en. Reset value 0x2.
- Reading MSG while the FIFO is empty returns 0x00000000 and does not pop.
- Writes to MSG or to unmapped offsets are acknowledged and have no effect.
- PHY input path:
  - midi_rxd passes through a 2-FF synchroniser.
  - States IDLE → START → DATA → STOP → IDLE.
  - IDLE: a falling edge while rx_en=1 enters START.
  - START: sample at BIT_CYC/2. If the line is high, return to IDLE (glitch rejection).
  - DATA: 8 samples, LSB first, spaced BIT_CYC apart.
  - STOP: one sample. 1 emits a byte strobe; 0 discards the byte and sets the framing-error bit.
- Parser:
  - 0x80–0xEF: latch running status; expected data bytes = 1 for Cx/Dx, 2 otherwise; clear any partial message.
  - 0xF0–0xF7: clear running status. Following data bytes are dropped until the next channel status byte.
  - 0xF8–0xFF: push a 1-byte message immediately. Running status and any partial message are untouched.
  - Data byte with no running status: dropped.
  - Message complete: push it, keep running status, reset the data index.
- FIFO:
  - Push while full: the new message is dropped and overrun is set.
  - Push and pop in the same cycle while full: both take effect and count is unchanged.
- irq = irq_en & nonempty, registered.

## Timing
- Reset (rst=0 at a clk edge) forces:
  - wb_ack_o=0, wb_dat_o=0, irq=0;
  - FIFO empty, STAT=0, CTRL=0x2;
  - PHY in IDLE, running status cleared.
- Reset mid-frame abandons the frame. The PHY then waits for a fresh falling edge.
- Wishbone access:
  - stb&cyc&!ack produces wb_ack_o=1 on the next cycle, with wb_dat_o valid in that same cycle. ack then drops for one cycle, so back-to-back accesses take at least 2 cycles.
  - A MSG pop takes effect at the ack edge. The STAT count reflects it on the following access.
- Byte strobe is asserted 1 cycle after the stop-bit sample. FIFO push happens 1 cycle after the strobe. irq rises 1 cycle after the push.
- Total latency from the stop-bit centre to irq is 3 cycles.
- Clearing rx_en mid-frame finishes the current frame; no new start bit is accepted afterwards.
- Bit counter width is $clog2(BIT_CYC). The counter reloads on every sample and never wraps.

## Structure
- Package midi_pkg holds:
  - register offsets and STAT/CTRL bit indices;
  - status class ranges (channel, system common, realtime);
  - function data_len(status) returning 0, 1 or 2;
  - the MSG field layout.
- Sub-module midi_rx_phy contains the synchroniser, bit FSM and framing check. Its outputs are byte[7:0], byte_stb and ferr_stb.
- The parser, FIFO and register file live in wb_midi_rx.

## Test plan
- Note On: serial 0x90 0x3C 0x64 → irq=1 (CTRL=0x3). MSG reads 0x83903C64, the next MSG read returns 0x00000000, and irq drops.
- Running status: 0x90 0x3C 0x64 0x3E 0x00 → MSG reads 0x83903C64, then 0x83903E00.
- Realtime interleave: 0x90 0x3C 0xF8 0x64 → MSG reads 0x81F80000, then 0x83903C64.
- Overrun: 0xC0 followed by data 0x00..0x04, with no reads →
  - STAT=0x43 (count 4, overrun, nonempty);
  - MSG reads 0x82C00000, 0x82C00100, 0x82C00200, 0x82C00300;
  - writing 0x2 to STAT then reads STAT=0x00.
- Framing and orphan data: a frame with stop bit 0 → STAT bit 2 set and nothing pushed. Data byte 0x40 sent after 0xF2 → dropped, count 0.
- Reset mid-frame: rst=0 during the 4th data bit → all outputs 0 and STAT=0. A subsequent clean 0xFE frame → MSG reads 0x81FE0000.
